// File: rtl/rv_ram32_sync.sv
// rv_ram32_sync: single-clock 32-bit word RAM slave for the picorv32 native bus.
// Byte-addressed, per-byte write strobes, one-cycle ack pulse one clock after accept.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous active-low reset
//   addr_valid in   1          request select from the address decoder
//   addr       in   ADDR_BITS  byte address; word index = addr[ADDR_BITS-1:2]
//   ack        out  1          registered one-cycle acknowledge
//   wdata      in   32         write data, lane i = wdata[8i+7:8i]
//   wr_en      in   4          byte write strobes; 4'b0000 = read
//   rdata      out  32         registered read data, valid while ack=1
module rv_ram32_sync #(
  parameter int unsigned ADDR_BITS = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 addr_valid,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 ack,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wr_en,
  output logic [31:0]          rdata
);

  localparam int unsigned WBITS = ADDR_BITS - 2;
  localparam int unsigned DEPTH = 2 ** WBITS;

  logic [31:0]      mem_q [DEPTH];
  logic [WBITS-1:0] word;
  logic             accept;
  logic             do_write;
  logic [31:0]      old_word;
  logic [31:0]      new_word;

  logic             ack_q;
  logic             ack_d;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;

  // Byte offset within the word is deliberately ignored.
  logic             unused_offset;
  assign unused_offset = ^addr[1:0];

  // The array starts at zero.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] = '0;
    end
  end

  assign word     = addr[ADDR_BITS-1:2];
  assign old_word = mem_q[word];

  // A request is taken only when no ack is outstanding, so a master
  // holding valid high gets accept/ack on alternating cycles.
  assign accept   = rst_n & addr_valid & ~ack_q;
  assign do_write = accept & (|wr_en);

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        new_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    ack_d   = accept;
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = old_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; do_write already masks writes during reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[word] <= new_word;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_rv_ram32_sync.sv
// tb_rv_ram32_sync: directed bench for rv_ram32_sync with a
// byte-lane memory model checked every cycle plus literal checks.
module tb_rv_ram32_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_valid;
  logic [7:0]  addr;
  logic        ack;
  logic [31:0] wdata;
  logic [3:0]  wr_en;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  rv_ram32_sync #(.ADDR_BITS(8), .INIT_FILE("")) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_valid (addr_valid),
    .addr       (addr),
    .ack        (ack),
    .wdata      (wdata),
    .wr_en      (wr_en),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  // ---------- model: 64 words, one ack per accepted request ----------
  logic [31:0] mem_m [64];
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_live = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ack   <= 1'b0;
      m_rdata <= '0;
      m_live  <= 1'b1;
    end else if (m_live) begin
      if (addr_valid && !m_ack) begin
        m_ack   <= 1'b1;
        m_rdata <= mem_m[addr[7:2]];
        mem_m[addr[7:2]] <= merge(mem_m[addr[7:2]], wdata, wr_en);
      end else begin
        m_ack <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------- per-cycle compare against the model ----------
  always @(negedge clk) begin
    if (m_live) begin
      chk("ack_vs_model", {31'b0, ack}, {31'b0, m_ack});
      chk("rdata_vs_model", rdata, m_rdata);
    end
  end

  // ---------- stimulus helpers (called at a negedge, ack=0) ----------
  task automatic access(input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd);
    addr_valid = 1'b1;
    addr       = a;
    wdata      = d;
    wr_en      = be;
    @(negedge clk);
    chk("ack_after_accept", {31'b0, ack}, 32'd1);
    rd         = rdata;
    addr_valid = 1'b0;
    wr_en      = 4'h0;
    wdata      = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ack_single_pulse", {31'b0, ack}, 32'd0);
  endtask

  logic [31:0] rd;
  logic [5:0]  pat;

  initial begin
    rst_n      = 1'b0;
    addr_valid = 1'b0;
    addr       = '0;
    wdata      = '0;
    wr_en      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: seed a word, then reset with a write request pending
    access(8'h00, 32'hCAFE_F00D, 4'hF, rd);
    rst_n      = 1'b0;
    addr_valid = 1'b1;
    addr       = 8'h00;
    wdata      = 32'h0;
    wr_en      = 4'hF;
    repeat (2) begin
      @(negedge clk);
      chk("reset_ack", {31'b0, ack}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
    end
    addr_valid = 1'b0;
    wr_en      = 4'h0;
    rst_n      = 1'b1;
    @(negedge clk);
    access(8'h00, 32'h0, 4'h0, rd);
    chk("reset_word_kept", rd, 32'hCAFE_F00D);

    // 2: write then read
    access(8'h04, 32'hDEAD_BEEF, 4'hF, rd);
    access(8'h04, 32'h0, 4'h0, rd);
    chk("read_back", rd, 32'hDEAD_BEEF);

    // 3: byte strobes
    access(8'h08, 32'h1122_3344, 4'hF, rd);
    access(8'h08, 32'hAABB_CCDD, 4'b0101, rd);
    chk("strobe_old_word", rd, 32'h1122_3344);
    access(8'h08, 32'h0, 4'h0, rd);
    chk("strobe_merge", rd, 32'h11BB_33DD);

    // 4: offset aliasing and top word
    access(8'h0C, 32'h5, 4'hF, rd);
    access(8'h0E, 32'h0, 4'h0, rd);
    chk("alias_read", rd, 32'h5);
    access(8'hFC, 32'hA5A5_0FC0, 4'hF, rd);
    access(8'hFC, 32'h0, 4'h0, rd);
    chk("top_word", rd, 32'hA5A5_0FC0);
    access(8'h00, 32'h0, 4'h0, rd);
    chk("top_no_wrap", rd, 32'hCAFE_F00D);

    // 5: valid held high six cycles
    addr_valid = 1'b1;
    addr       = 8'h04;
    wr_en      = 4'h0;
    for (int i = 0; i < 6; i++) begin
      pat[i] = ack;
      @(negedge clk);
    end
    addr_valid = 1'b0;
    chk("held_pattern", {26'b0, pat}, 32'b101010);
    chk("held_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // 6: reset mid-operation
    addr_valid = 1'b1;
    addr       = 8'h10;
    wdata      = 32'h1234;
    wr_en      = 4'hF;
    @(negedge clk);
    chk("midop_accept", {31'b0, ack}, 32'd1);
    rst_n      = 1'b0;
    wdata      = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("midop_ack_cancel", {31'b0, ack}, 32'd0);
    @(negedge clk);
    chk("midop_ack_low", {31'b0, ack}, 32'd0);
    addr_valid = 1'b0;
    wr_en      = 4'h0;
    rst_n      = 1'b1;
    @(negedge clk);
    access(8'h10, 32'h0, 4'h0, rd);
    chk("midop_word_kept", rd, 32'h0000_1234);

    // idle: rdata must hold
    repeat (3) @(negedge clk);
    chk("idle_hold", rdata, 32'h0000_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
